guess_engine: RTL
=================

# guess_engine

Parametrised number-guessing engine: the next-generation core of the guessing game. It generates a secret from a free-running LFSR by rejection sampling. It tracks the shrinking low/high window on each entered guess and enforces a configurable attempt limit with win/lose outcomes. It sits between the switch/button input stage and the binary-to-BCD/seven-segment display path, which consume `ll`, `hl` and `tries_left` directly.

## Interface
- `WIDTH`, 7: bit width of guess, secret, `ll`, `hl`.
- `MAX_VAL`, 99: exclusive upper bound of the window; legal secret is 1..MAX_VAL-1; must satisfy 2 ≤ MAX_VAL ≤ 2**WIDTH-1.
- `MAX_TRIES`, 7: accepted guesses allowed per round; ≥1.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `genrand` in 1: level; start a new round.
- `enter` in 1: level (debounced button); rising edge submits `guess`.
- `guess` in WIDTH: player's guess.
- `ll` out WIDTH: current exclusive low limit.
- `hl` out WIDTH: current exclusive high limit.
- `tries_left` out $clog2(MAX_TRIES+1): remaining attempts.
- `ready` out 1: high in PLAY only.
- `outrange` out 1: last submitted guess was outside (ll, hl).
- `done` out 1: round won.
- `lose` out 1: round lost.
- `secret` out WIDTH: secret value while `done` or `lose`, else 0.

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), steps every cycle in every state, reset to SEED; candidate = lfsr[WIDTH-1:0].
- States: IDLE, GEN, PLAY, CHECK, WIN, LOSE. Reset → IDLE.
- IDLE: `genrand`=1 → GEN.
- GEN: window reset (`ll`=0, `hl`=MAX_VAL, `tries_left`=MAX_TRIES, flags cleared). If 0 < candidate < MAX_VAL: latch secret, → PLAY. Otherwise stay in GEN (retry next cycle).
- Enter edge: `enter_q` register; edge = enter & ~enter_q; `enter_q` resets to 0 and updates every cycle in all states.
- PLAY: edge → latch `guess` into internal register, → CHECK. No edge → stay.
- CHECK, compared against the latched guess g, in priority order:
  - g ≤ ll or g ≥ hl: `outrange`=1; tries unchanged; → PLAY.
  - g == secret: `outrange`=0, `done`=1; → WIN.
  - g < secret: `ll`=g, `tries_left`-1, `outrange`=0.
  - g > secret: `hl`=g, `tries_left`-1, `outrange`=0.
  - After a miss: if the decremented tries = 0 → `lose`=1, LOSE; else → PLAY.
- A winning guess does not decrement `tries_left`.
- WIN/LOSE: hold all outputs; `genrand` → GEN.
- `genrand` in PLAY or CHECK also → GEN (abandons the round); `genrand` beats a simultaneous enter edge.
- Comparisons unsigned, WIDTH bits; `tries_left` never underflows.

## Timing
- Reset values: `ll`=0, `hl`=MAX_VAL, `tries_left`=MAX_TRIES, `ready`=0, `outrange`=0, `done`=0, `lose`=0, `secret`=0, LFSR=SEED, state IDLE.
- `genrand` sampled at edge N → GEN from N+1. Secret latched at the first GEN cycle with a legal candidate → `ready`=1 the following cycle. Latency is deterministic given SEED and cycle count.
- Enter edge at clock edge N (in PLAY) → CHECK at N+1 → `ll`/`hl`/`tries_left`/flags updated and next state visible after edge N+2.
- Enter held high submits exactly one guess. An edge occurring in CHECK, GEN, WIN, LOSE or IDLE is ignored (not queued).
- `outrange` stays high until the next checked guess or GEN.
- Async reset mid-round (any state) returns to reset values immediately; `done`/`lose` cleared.

## Test plan
- Reset → `ll`=0, `hl`=99, `tries_left`=7, `ready`=0, `secret`=0; `genrand` pulse → `ready`=1 after GEN, with the secret S matching the bench LFSR model (SEED 16'hACE1), 0<S<99.
- Play with S: guess S-1 → `ll`=S-1, `tries_left`=6; guess S+1 → `hl`=S+1, `tries_left`=5; guess S → `done`=1, `secret`=S, `tries_left`=5.
- Guess 0, then 99, then `ll` itself → `outrange`=1 each time, `tries_left` unchanged; next legal guess clears `outrange`.
- MAX_TRIES=3: three misses → `lose`=1 two cycles after the third edge, `tries_left`=0, `secret`=S; further enter edges → no change; `genrand` → new round, `tries_left`=3.
- Enter held high for 20 cycles → one decrement only; `genrand` and enter edge in same PLAY cycle → GEN, no guess processed.
- Async `rst` low during CHECK → all outputs at reset values without a clock edge; WIDTH=10, MAX_VAL=1000 run → secret in 1..999, window updates correct.

Source files
------------

// File: rtl/guess_engine.sv
// guess_engine
//
// Number-guessing core. A free-running 16-bit Galois LFSR supplies candidate
// secrets. A new round starts on genrand. Candidates outside 1..MAX_VAL-1 are
// rejected, and the next LFSR value is tried on the following cycle. During
// play, each rising edge of enter submits guess. The open window (ll, hl) then
// shrinks toward the secret until the player wins or runs out of attempts.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   rst        : asynchronous active-low reset
//   genrand    : level, start a new round (also abandons a round in progress)
//   enter      : level from the debounced button; its rising edge submits guess
//   guess      : player's guess, WIDTH bits, unsigned
//   ll, hl     : current exclusive low / high window limits
//   tries_left : attempts remaining in this round
//   ready      : high while waiting for a guess
//   outrange   : the last checked guess fell outside (ll, hl)
//   done       : round won
//   lose       : round lost
//   secret     : the secret while done or lose, otherwise 0

module guess_engine #(
  parameter int           WIDTH     = 7,
  parameter int           MAX_VAL   = 99,
  parameter int           MAX_TRIES = 7,
  parameter logic [15:0]  SEED      = 16'hACE1,
  localparam int          TW        = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             genrand,
  input  logic             enter,
  input  logic [WIDTH-1:0] guess,
  output logic [WIDTH-1:0] ll,
  output logic [WIDTH-1:0] hl,
  output logic [TW-1:0]    tries_left,
  output logic             ready,
  output logic             outrange,
  output logic             done,
  output logic             lose,
  output logic [WIDTH-1:0] secret
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [TW-1:0]    MAX_T = TW'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    PLAY  = 3'd2,
    CHECK = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic             enter_q;
  logic [WIDTH-1:0] guess_r;
  logic [WIDTH-1:0] secret_r;

  logic             enter_rise;
  logic [WIDTH-1:0] cand;
  logic             cand_ok;
  logic             g_out;
  logic [TW-1:0]    tries_dec;

  // Galois step for x^16+x^14+x^13+x^11+1: shift right, fold in the tap mask
  // whenever the bit shifted out was set.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  assign enter_rise = enter & ~enter_q;
  assign cand       = lfsr[WIDTH-1:0];
  assign cand_ok    = (cand != '0) && (cand < MAX_V);
  // The window is exclusive on both sides, so the limits themselves are out.
  assign g_out      = (guess_r <= ll) || (guess_r >= hl);
  // Saturating decrement; a round never reaches CHECK with zero tries left,
  // but the guard keeps the counter from wrapping regardless.
  assign tries_dec  = (tries_left != '0) ? (tries_left - TW'(1)) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lfsr       <= SEED;
      enter_q    <= 1'b0;
      guess_r    <= '0;
      secret_r   <= '0;
      ll         <= '0;
      hl         <= MAX_V;
      tries_left <= MAX_T;
      ready      <= 1'b0;
      outrange   <= 1'b0;
      done       <= 1'b0;
      lose       <= 1'b0;
      secret     <= '0;
    end else begin
      // The LFSR and the enter history run in every state, so the secret
      // depends on how many cycles elapsed before genrand.
      lfsr    <= lfsr_step(lfsr);
      enter_q <= enter;

      case (state)
        IDLE: begin
          if (genrand) begin
            state <= GEN;
            ready <= 1'b0;
          end
        end

        GEN: begin
          ll         <= '0;
          hl         <= MAX_V;
          tries_left <= MAX_T;
          outrange   <= 1'b0;
          done       <= 1'b0;
          lose       <= 1'b0;
          secret     <= '0;
          if (cand_ok) begin
            secret_r <= cand;
            state    <= PLAY;
            ready    <= 1'b1;
          end
        end

        PLAY: begin
          // genrand wins over a simultaneous enter edge.
          if (genrand) begin
            state <= GEN;
            ready <= 1'b0;
          end else if (enter_rise) begin
            guess_r <= guess;
            state   <= CHECK;
            ready   <= 1'b0;
          end
        end

        CHECK: begin
          if (genrand) begin
            state <= GEN;
            ready <= 1'b0;
          end else if (g_out) begin
            outrange <= 1'b1;
            state    <= PLAY;
            ready    <= 1'b1;
          end else if (guess_r == secret_r) begin
            outrange <= 1'b0;
            done     <= 1'b1;
            secret   <= secret_r;
            state    <= WIN;
          end else begin
            if (guess_r < secret_r) ll <= guess_r;
            else                    hl <= guess_r;
            tries_left <= tries_dec;
            outrange   <= 1'b0;
            if (tries_dec == '0) begin
              lose   <= 1'b1;
              secret <= secret_r;
              state  <= LOSE;
            end else begin
              state <= PLAY;
              ready <= 1'b1;
            end
          end
        end

        WIN, LOSE: begin
          if (genrand) begin
            state <= GEN;
            ready <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
